wl_host_sequencer: RTL

- Hardware host-side initiator for the UART command protocol that the on-chip control unit answers.
- Serialises one word-length configuration frame (fractional WL per channel, per DUT system) into the UART transmitter's byte interface.
- Collects the MSE response frame from the UART receiver's byte interface and presents both 64-bit MSE results with checksum and timeout status.
- Used for self-test and board-to-board optimisation runs without a PC.

---
 rtl/wl_host_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wl_host_sequencer.sv
// Host-side UART command initiator: sends one word-length configuration frame,
// then collects and checks the MSE response frame, with a per-byte timeout.
module wl_host_sequencer #(
  parameter int NUM_CHAN = 15,
  parameter int NUM_SYS  = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [8*NUM_SYS*NUM_CHAN-1:0] cmd_frac,
  input  logic                          com_txready,
  output logic                          com_txvalid,
  output logic [7:0]                    com_txdata,
  input  logic                          com_rxvalid,
  input  logic [7:0]                    com_rxdata,
  output logic                          res_valid,
  output logic [63:0]                   res_mse0,
  output logic [63:0]                   res_mse1,
  output logic [1:0]                    res_err,
  output logic                          busy
);

  localparam int NB = NUM_SYS * NUM_CHAN;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] TX_HDR_BYTE = 8'hA5;
  localparam logic [7:0] RX_HDR_BYTE = 8'h5A;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_HDR,
    S_TX_PAY,
    S_TX_CHK,
    S_RX_HDR,
    S_RX_PAY,
    S_RX_CHK,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [8*NB-1:0]   frac_q;
  logic [PW-1:0]     pay_cnt;
  logic [7:0]        tx_xor;
  logic [3:0]        rx_cnt;
  logic [127:0]      rx_sh;
  logic [7:0]        rx_xor;
  logic [TW-1:0]     to_cnt;

  logic              accept;
  logic              rx_state;
  logic              rx_byte;
  logic              to_hit;
  logic              pay_last;
  logic [7:0]        pay_byte;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);
  assign accept    = cmd_valid & cmd_ready;

  assign rx_state  = (state == S_RX_HDR) || (state == S_RX_PAY) || (state == S_RX_CHK);
  assign rx_byte   = rx_state & com_rxvalid;
  assign to_hit    = rx_state & ~com_rxvalid & (to_cnt == TW'(TIMEOUT - 1));
  assign pay_last  = (pay_cnt == PW'(NB - 1));
  assign pay_byte  = frac_q[{pay_cnt, 3'b000} +: 8];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    com_txvalid = 1'b0;
    com_txdata  = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_TX_HDR;
      end
      S_TX_HDR: begin
        if (com_txready) begin
          com_txvalid = 1'b1;
          com_txdata  = TX_HDR_BYTE;
          state_nxt   = S_TX_PAY;
        end
      end
      S_TX_PAY: begin
        if (com_txready) begin
          com_txvalid = 1'b1;
          com_txdata  = pay_byte;
          if (pay_last) state_nxt = S_TX_CHK;
        end
      end
      S_TX_CHK: begin
        if (com_txready) begin
          com_txvalid = 1'b1;
          com_txdata  = tx_xor;
          state_nxt   = S_RX_HDR;
        end
      end
      S_RX_HDR: begin
        if (to_hit)                                    state_nxt = S_DONE;
        else if (rx_byte && com_rxdata == RX_HDR_BYTE) state_nxt = S_RX_PAY;
      end
      S_RX_PAY: begin
        if (to_hit)                         state_nxt = S_DONE;
        else if (rx_byte && rx_cnt == 4'd15) state_nxt = S_RX_CHK;
      end
      S_RX_CHK: begin
        if (to_hit || rx_byte) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      frac_q   <= '0;
      pay_cnt  <= '0;
      tx_xor   <= 8'h00;
      rx_cnt   <= 4'd0;
      rx_sh    <= '0;
      rx_xor   <= 8'h00;
      to_cnt   <= '0;
      res_mse0 <= 64'h0;
      res_mse1 <= 64'h0;
      res_err  <= ERR_OK;
    end else begin
      state <= state_nxt;

      if (accept) begin
        frac_q  <= cmd_frac;
        pay_cnt <= '0;
        tx_xor  <= 8'h00;
      end

      if (state == S_TX_PAY && com_txready) begin
        pay_cnt <= pay_cnt + 1'b1;
        tx_xor  <= tx_xor ^ pay_byte;
      end

      // Receive bookkeeping starts fresh once the checksum byte leaves.
      if (state == S_TX_CHK && com_txready) begin
        to_cnt <= '0;
        rx_cnt <= 4'd0;
        rx_xor <= 8'h00;
      end

      if (rx_state) to_cnt <= com_rxvalid ? '0 : to_cnt + 1'b1;

      if (state == S_RX_PAY && rx_byte) begin
        rx_sh  <= {rx_sh[119:0], com_rxdata};
        rx_xor <= rx_xor ^ com_rxdata;
        rx_cnt <= rx_cnt + 1'b1;
      end

      // Results are loaded on entry to DONE so they are valid alongside res_valid.
      if (state == S_RX_CHK && rx_byte) begin
        res_mse0 <= rx_sh[127:64];
        res_mse1 <= rx_sh[63:0];
        res_err  <= (com_rxdata == rx_xor) ? ERR_OK : ERR_CHK;
      end else if (to_hit) begin
        res_err  <= ERR_TIMEOUT;
      end
    end
  end

endmodule
